// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: FSM state, record layout and record width helper.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } trace_state_t;

  localparam int unsigned TRACE_XLEN  = 32;
  localparam int unsigned TRACE_SEQ_W = 16;
  localparam int unsigned INS_W       = 32;
  localparam int unsigned RD_W        = 5;

  // Field order matches the packed record word stored in trace_ram (pc in the MSBs).
  typedef struct packed {
    logic [TRACE_XLEN-1:0]  pc;
    logic [INS_W-1:0]       ins;
    logic [RD_W-1:0]        rd;
    logic                   wen;
    logic [TRACE_XLEN-1:0]  wdata;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_rec_t;

  function automatic int unsigned rec_w(input int unsigned xlen, input int unsigned seq_w);
    return 2 * xlen + INS_W + RD_W + 1 + seq_w;
  endfunction

  localparam int unsigned REC_W = rec_w(TRACE_XLEN, TRACE_SEQ_W);

endpackage

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures one retirement record per committed instruction into a circular buffer
// with halt-PC trigger, stop-on-full or wrap-around, and an FWFT readout port.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned SEQ_W     = 16,
  parameter int unsigned WRAP_MODE = 0,
  parameter int unsigned FILTER_X0 = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       halt_en,
  input  logic [XLEN-1:0]            halt_pc,
  input  logic                       commit_valid,
  input  logic [XLEN-1:0]            commit_pc,
  input  logic [31:0]                commit_ins,
  input  logic [4:0]                 commit_rd,
  input  logic                       commit_wen,
  input  logic [XLEN-1:0]            commit_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_ins,
  output logic [4:0]                 out_rd,
  output logic                       out_wen,
  output logic [XLEN-1:0]            out_wdata,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       capturing,
  output logic                       done,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned W     = rec_w(XLEN, SEQ_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  trace_state_t     state;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [SEQ_W-1:0] seq;
  logic             done_q, ovf_q;

  logic [W-1:0]     wr_rec, rd_rec;
  logic             pop, push, full, store, drop, hit, rec_wen;

  logic [XLEN-1:0]  h_pc, h_wdata;
  logic [31:0]      h_ins;
  logic [4:0]       h_rd;
  logic             h_wen;
  logic [SEQ_W-1:0] h_seq;

  always_comb begin
    pop     = (cnt != '0) & out_ready;
    full    = (cnt == FULL_CNT);
    push    = (state == ARMED) & commit_valid & ~arm;
    drop    = push & full & ~pop & (WRAP_MODE == 0);
    store   = push & ~drop;
    hit     = push & halt_en & (commit_pc == halt_pc);
    rec_wen = commit_wen & ~((FILTER_X0 != 0) & (commit_rd == '0));
  end

  assign wr_rec = {commit_pc, commit_ins, commit_rd, rec_wen, commit_wdata, seq};

  trace_ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (wr_rec),
    .raddr (rd_ptr),
    .rdata (rd_rec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      seq    <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (arm) begin
      state  <= ARMED;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      seq    <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 1'b1;
      end
      // An overwrite at full (wrap mode, no pop) retires the oldest record like a pop.
      if (pop | (store & full)) rd_ptr <= rd_ptr + 1'b1;
      if (store & ~pop & ~full)  cnt <= cnt + 1'b1;
      else if (pop & ~store)     cnt <= cnt - 1'b1;
      if (push & full & ~pop) ovf_q <= 1'b1;
      if (drop | hit) begin
        state  <= DONE;
        done_q <= 1'b1;
      end
    end
  end

  assign {h_pc, h_ins, h_rd, h_wen, h_wdata, h_seq} = rd_rec;

  assign out_valid = (cnt != '0);
  assign out_pc    = out_valid ? h_pc    : '0;
  assign out_ins   = out_valid ? h_ins   : '0;
  assign out_rd    = out_valid ? h_rd    : '0;
  assign out_wen   = out_valid ? h_wen   : 1'b0;
  assign out_wdata = out_valid ? h_wdata : '0;
  assign out_seq   = out_valid ? h_seq   : '0;
  assign count     = cnt;
  assign capturing = (state == ARMED);
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Parametrised, synthesizable successor to the bench-side PC/instruction/register-write print loop.
- Sits beside the datapath and captures one retirement record per committed instruction (PC change) into an on-chip circular buffer.
- Supports a programmable halt-PC trigger, stop-when-full or wrap-around modes, and a first-word-fall-through valid/ready readout port for a debug host or bench.

Parameters:
XLEN, 32, data/PC width
DEPTH, 16, record slots; power of two, >= 2
SEQ_W, 16, width of per-record sequence number
WRAP_MODE, 0, 0 = stop capturing when full; 1 = overwrite oldest record
FILTER_X0, 1, 1 = writes to x0 are recorded with wen=0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
arm  in  1  pulse: flush buffer, clear status, start capture
halt_en  in  1  enable halt-PC trigger
halt_pc  in  XLEN  trigger PC
commit_valid  in  1  an instruction retired this cycle (PC changed)
commit_pc  in  XLEN  PC of retired instruction
commit_ins  in  32  instruction word
commit_rd  in  5  destination register
commit_wen  in  1  register-file write enable
commit_wdata  in  XLEN  write-back data
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head record
out_pc  out  XLEN  head record PC
out_ins  out  32  head record instruction
out_rd  out  5  head record rd
out_wen  out  1  head record write enable (post-filter)
out_wdata  out  XLEN  head record write data
out_seq  out  SEQ_W  head record sequence number
count  out  $clog2(DEPTH+1)  records held
capturing  out  1  state == ARMED
done  out  1  sticky: halt trigger hit or stopped on full
overflow  out  1  sticky: a record was dropped or overwritten

Behaviour:
- Reset (rst low, asynchronous): state IDLE. Pointers, count, seq counter, done and overflow are 0; out_valid is 0; all out_* data are 0.
- States are IDLE, ARMED and DONE.
- arm (any state) -> ARMED next edge. Flushes pointers/count, clears done/overflow, zeroes seq.
  - arm has priority: a commit or pop in the same cycle is ignored.
- ARMED: on commit_valid, write record {pc, ins, rd, wen', wdata, seq}.
  - wen' = commit_wen & ~(FILTER_X0 & rd==0).
  - seq increments once per captured record and wraps modulo 2^SEQ_W.
- Halt trigger: halt_en and commit_pc==halt_pc on a captured commit. The record is stored, then state -> DONE and done=1.
- Full, WRAP_MODE=0:
  - A commit that arrives when count==DEPTH and no pop occurs the same cycle is dropped, sets overflow=1, and moves state -> DONE with done=1.
  - The commit that fills the last slot is stored normally.
- Full, WRAP_MODE=1:
  - A commit with count==DEPTH and no pop overwrites the oldest record and advances the read pointer.
  - Count stays DEPTH; overflow=1; state remains ARMED.
- Simultaneous push and pop: count unchanged, both pointers advance, no overflow, including at full.
- Readout (all states):
  - out_valid = (count!=0).
  - out_* are driven combinationally from the head slot; pop on out_valid & out_ready.
  - A pop when empty is ignored.
  - out_* hold their value while out_valid & ~out_ready.
- Latency: a commit captured at edge N is visible on out_* with out_valid=1 after edge N when the buffer was empty (one cycle).
- IDLE/DONE: commits are ignored and seq is frozen; draining continues.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Reset mid-capture discards all records immediately.

Decomposition:
- Package trace_pkg holds:
  - trace_state_t enum {IDLE, ARMED, DONE};
  - trace_rec_t packed struct (pc, ins, rd, wen, wdata, seq), parameterised via localparam widths;
  - REC_W helper.
- Sub-module trace_ram: DEPTH x REC_W storage with one synchronous write port and one asynchronous read port.
- Pointer, count, FSM and status logic stay in commit_trace_buffer.

Test Plan:
- Reset then arm; 3 commits PC=0,4,8 with rd=1,2,3 and wen=1 -> count=3; pops return seq 0,1,2 with matching PCs; out_valid falls after the 3rd pop.
- halt_en=1, halt_pc=0x20; commits PC=0x00..0x28 step 4 -> 9 records (last PC=0x20), done=1, capturing=0; commits 0x24/0x28 not stored.
- WRAP_MODE=0, DEPTH=16; 20 commits, no pops -> count=16, records seq 0..15, overflow=1, done=1.
- WRAP_MODE=1, DEPTH=16; 20 commits -> count=16, head seq=4, tail seq=19, overflow=1, capturing=1.
- Commit rd=0 with wen=1 and FILTER_X0=1 -> out_wen=0. At full with a simultaneous commit and pop -> count stays 16, overflow stays 0.
- arm asserted in the same cycle as commit_valid and out_ready with count=5 -> count=0, seq restarts at 0, that commit not stored. rst pulled low mid-capture -> all outputs 0 asynchronously.
